// File: rtl/da_sequencer.sv
// Sweeps the 3-bit decode-stage select through all eight codes, holding each
// for DWELL cycles, in up, down, ping-pong or single-shot order.
module da_sequencer #(
  parameter int DWELL = 100,
  localparam int CW = $clog2(DWELL + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [2:0] da,
  output logic       da_valid,
  output logic       busy,
  output logic       wrap,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PING = 2'b10;
  localparam logic [1:0] M_ONCE = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t     state, state_n;
  logic [1:0] mode_q, mode_n;
  logic       dir, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] da_n;
  logic       valid_n, busy_n, wrap_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= 2'b00;
      dir      <= 1'b0;
      cnt      <= '0;
      da       <= 3'd0;
      da_valid <= 1'b0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      dir      <= dir_n;
      cnt      <= cnt_n;
      da       <= da_n;
      da_valid <= valid_n;
      busy     <= busy_n;
      wrap     <= wrap_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    dir_n   = dir;
    cnt_n   = cnt;
    da_n    = da;
    valid_n = da_valid;
    busy_n  = busy;
    wrap_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // stop beats start when both arrive together
        if (start && !stop) begin
          state_n = RUN;
          mode_n  = mode;
          dir_n   = (mode == M_DOWN);
          cnt_n   = '0;
          da_n    = (mode == M_DOWN) ? 3'd7 : 3'd0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          unique case (mode_q)
            M_UP: begin
              da_n   = da + 3'd1;
              wrap_n = (da == 3'd7);
            end
            M_DOWN: begin
              da_n   = da - 3'd1;
              wrap_n = (da == 3'd0);
            end
            M_PING: begin
              // turn around one step early so endpoints are not repeated
              if (!dir) begin
                da_n = da + 3'd1;
                if (da == 3'd6) dir_n = 1'b1;
              end else begin
                da_n = da - 3'd1;
                if (da == 3'd1) begin
                  dir_n  = 1'b0;
                  wrap_n = 1'b1;
                end
              end
            end
            M_ONCE: begin
              if (da == 3'd7) begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                wrap_n  = 1'b1;
                done_n  = 1'b1;
              end else begin
                da_n = da + 3'd1;
              end
            end
          endcase
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_da_sequencer.sv
// Scoreboard bench: two instances (DWELL=4 and DWELL=1) share stimulus and
// are compared each cycle against a sequence-index reference model.
module tb_da_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [2:0] da_a, da_b;
  logic       va, ba, wa, dna;
  logic       vb, bb, wb, dnb;

  da_sequencer #(.DWELL(4)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .da(da_a), .da_valid(va), .busy(ba), .wrap(wa), .done(dna)
  );

  da_sequencer #(.DWELL(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .da(da_b), .da_valid(vb), .busy(bb), .wrap(wb), .done(dnb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit run;
    int m;
    int t;
    int da;
    bit v;
    bit b;
    bit w;
    bit d;
  } mdl_t;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;
  int errors = 0;
  int checks = 0;

  function automatic mdl_t zero_m();
    mdl_t z;
    z.run = 0; z.m = 0; z.t = 0; z.da = 0;
    z.v = 0; z.b = 0; z.w = 0; z.d = 0;
    return z;
  endfunction

  // code shown during the k-th dwell period after start
  function automatic int code(int m, int k);
    int p;
    p = k % 14;
    case (m)
      0: return k % 8;
      1: return 7 - (k % 8);
      2: return (p <= 7) ? p : 14 - p;
      default: return k;
    endcase
  endfunction

  function automatic mdl_t step(mdl_t s, bit st, bit sp, int m, int dw);
    mdl_t n;
    int k;
    n = s;
    n.w = 0;
    n.d = 0;
    if (!s.run) begin
      if (st && !sp) begin
        n.run = 1; n.m = m; n.t = 0;
        n.da = code(m, 0); n.v = 1; n.b = 1;
      end
    end else if (sp) begin
      n.run = 0; n.v = 0; n.b = 0; n.d = 1;
    end else begin
      n.t = s.t + 1;
      if (n.t % dw == 0) begin
        k = n.t / dw;
        if (s.m == 3 && k == 8) begin
          n.run = 0; n.v = 0; n.b = 0; n.d = 1; n.w = 1;
        end else begin
          n.da = code(s.m, k);
          if (s.m == 2) n.w = (k % 14 == 0);
          else if (s.m != 3) n.w = (k % 8 == 0);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] pk(mdl_t s);
    return {3'(s.da), s.v, s.b, s.w, s.d};
  endfunction

  function automatic void cmp(string nm, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t da/valid/busy/wrap/done got %b required %b",
               nm, $time, act, exp);
    end
  endfunction

  // monitor: pops one expectation per cycle just after the active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("dwell4", {da_a, va, ba, wa, dna}, e.a);
      cmp("dwell1", {da_b, vb, bb, wb, dnb}, e.b);
    end
  end

  task automatic cyc(input bit r, input bit st, input bit sp,
                     input logic [1:0] m);
    @(negedge clk);
    rst = r;
    start = st;
    stop = sp;
    mode = m;
    if (r) begin
      ma = zero_m();
      mb = zero_m();
    end else begin
      ma = step(ma, st, sp, int'(m), 4);
      mb = step(mb, st, sp, int'(m), 1);
    end
    q.push_back({pk(ma), pk(mb)});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, mode);
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_a", {da_a, va, ba, wa, dna}, 7'd0);
    cmp("async_rst_b", {da_b, vb, bb, wb, dnb}, 7'd0);
    ma = zero_m();
    mb = zero_m();
    q.push_back('0);
    repeat (hold) cyc(1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    bit r, st, sp;
    logic [1:0] m;
    ma = zero_m();
    mb = zero_m();
    #1;
    cmp("por_a", {da_a, va, ba, wa, dna}, 7'd0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    async_reset(2);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    idle(20);
    // up-continuous
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    idle(40);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    idle(3);
    // ping-pong
    cyc(1'b0, 1'b1, 1'b0, 2'b10);
    idle(20);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    idle(3);
    // single-shot, then restart
    cyc(1'b0, 1'b1, 1'b0, 2'b11);
    idle(40);
    cyc(1'b0, 1'b1, 1'b0, 2'b11);
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    idle(3);
    // down, stop while da=5, then start+stop collision
    cyc(1'b0, 1'b1, 1'b0, 2'b01);
    idle(9);
    cyc(1'b0, 1'b0, 1'b1, 2'b01);
    idle(4);
    cyc(1'b0, 1'b1, 1'b1, 2'b10);
    cyc(1'b0, 1'b1, 1'b1, 2'b00);
    idle(4);
    // reset mid-run, then a clean restart
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    idle(13);
    async_reset(1);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    idle(12);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      m  = 2'($urandom_range(0, 3));
      if (r) begin
        cyc(1'b1, 1'b0, 1'b0, m);
        cyc(1'b1, 1'b0, 1'b0, m);
      end else begin
        cyc(1'b0, st, sp, m);
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
